// File: rtl/uart_reg_sequencer.sv
// uart_reg_sequencer
//   Owns the UART register-file access port. After reset (or on cfg_start)
//   it programs divisor, line format and FIFO control with five back-to-back
//   writes. It then serves single register accesses from two requesters,
//   A and B, with round-robin arbitration.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   cfg_start             pulse: (re)run the init sequence
//   cfg_div/lcr/fcr       init values (lcr bit7 ignored, DLAB forced by sequence)
//   init_done             init sequence complete; requests accepted only when 1
//   x_valid/we/addr/wdata request from port x (a or b)
//   x_ready               1-cycle pulse, same cycle as the grant
//   x_rsp_valid           1-cycle pulse when the access completes
//   rsp_rdata             read data, valid with rsp_valid, held until next read
//   reg_wr_o/rd_o         register-file strobes (single cycle, never together)
//   reg_addr_o/din_o      register-file address / write data (hold when idle)
//   reg_dout_i            register-file read data (registered in the reg file)
//
// RD_LAT is the number of cycles from the edge raising reg_rd_o to the edge
// capturing reg_dout_i; it must be at least 2.
module uart_reg_sequencer #(
    parameter bit AUTO_INIT = 1'b1,
    parameter int RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    input  logic [15:0] cfg_div,
    input  logic [7:0]  cfg_lcr,
    input  logic [7:0]  cfg_fcr,
    output logic        init_done,
    input  logic        a_valid,
    input  logic        a_we,
    input  logic [2:0]  a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ready,
    output logic        a_rsp_valid,
    input  logic        b_valid,
    input  logic        b_we,
    input  logic [2:0]  b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ready,
    output logic        b_rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        reg_wr_o,
    output logic        reg_rd_o,
    output logic [2:0]  reg_addr_o,
    output logic [7:0]  reg_din_o,
    input  logic [7:0]  reg_dout_i
);

    typedef enum logic [3:0] {
        IDLE_RST, INIT0, INIT1, INIT2, INIT3, INIT4,
        IDLE, WR, RD0, RDW, RDCAP
    } state_t;

    // RDW lasts RD_LAT-1 cycles: counter loads RD_LAT-2 and counts to zero.
    localparam int CW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

    state_t        state;
    logic          rr_b;        // round-robin pointer: 0 = A next, 1 = B next
    logic          cur_b;       // port owning the access in flight
    logic          start_pend;  // cfg_start seen during an access
    logic [CW-1:0] rd_cnt;
    logic          can_acc;
    logic          grant_a;
    logic          grant_b;

    // Init writes: {addr, data}. The LCR is written twice, first with DLAB
    // set to open the divisor latches, then with DLAB clear.
    function automatic logic [10:0] init_word(input logic [2:0] step);
        case (step)
            3'd0:    init_word = {3'd3, cfg_lcr | 8'h80};
            3'd1:    init_word = {3'd0, cfg_div[7:0]};
            3'd2:    init_word = {3'd1, cfg_div[15:8]};
            3'd3:    init_word = {3'd3, cfg_lcr & 8'h7F};
            default: init_word = {3'd2, cfg_fcr};
        endcase
    endfunction

    // Grants are combinational so ready pulses in the cycle the request is
    // taken. A pending or fresh cfg_start wins over new requests.
    always_comb begin
        can_acc = (state == IDLE) && init_done && !cfg_start && !start_pend;
        grant_a = can_acc && a_valid && (!b_valid || !rr_b);
        grant_b = can_acc && b_valid && (!a_valid ||  rr_b);
        a_ready = grant_a;
        b_ready = grant_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE_RST;
            init_done   <= 1'b0;
            rr_b        <= 1'b0;
            cur_b       <= 1'b0;
            start_pend  <= 1'b0;
            rd_cnt      <= '0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            rsp_rdata   <= 8'h00;
            reg_wr_o    <= 1'b0;
            reg_rd_o    <= 1'b0;
            reg_addr_o  <= 3'd0;
            reg_din_o   <= 8'h00;
        end else begin
            reg_wr_o    <= 1'b0;
            reg_rd_o    <= 1'b0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;

            if (cfg_start && (state == WR || state == RD0 ||
                              state == RDW || state == RDCAP))
                start_pend <= 1'b1;

            case (state)
                IDLE_RST: begin
                    if (AUTO_INIT || cfg_start) begin
                        state                   <= INIT0;
                        reg_wr_o                <= 1'b1;
                        {reg_addr_o, reg_din_o} <= init_word(3'd0);
                    end
                end
                INIT0: begin
                    state                   <= INIT1;
                    reg_wr_o                <= 1'b1;
                    {reg_addr_o, reg_din_o} <= init_word(3'd1);
                end
                INIT1: begin
                    state                   <= INIT2;
                    reg_wr_o                <= 1'b1;
                    {reg_addr_o, reg_din_o} <= init_word(3'd2);
                end
                INIT2: begin
                    state                   <= INIT3;
                    reg_wr_o                <= 1'b1;
                    {reg_addr_o, reg_din_o} <= init_word(3'd3);
                end
                INIT3: begin
                    state                   <= INIT4;
                    reg_wr_o                <= 1'b1;
                    {reg_addr_o, reg_din_o} <= init_word(3'd4);
                end
                INIT4: begin
                    state     <= IDLE;
                    init_done <= 1'b1;
                end
                IDLE: begin
                    if (cfg_start || start_pend) begin
                        start_pend              <= 1'b0;
                        init_done               <= 1'b0;
                        state                   <= INIT0;
                        reg_wr_o                <= 1'b1;
                        {reg_addr_o, reg_din_o} <= init_word(3'd0);
                    end else if (grant_a || grant_b) begin
                        cur_b      <= grant_b;
                        reg_addr_o <= grant_b ? b_addr : a_addr;
                        if (a_valid && b_valid)
                            rr_b <= !rr_b;
                        if (grant_b ? b_we : a_we) begin
                            state       <= WR;
                            reg_wr_o    <= 1'b1;
                            reg_din_o   <= grant_b ? b_wdata : a_wdata;
                            a_rsp_valid <= grant_a;
                            b_rsp_valid <= grant_b;
                        end else begin
                            state    <= RD0;
                            reg_rd_o <= 1'b1;
                        end
                    end
                end
                WR: state <= IDLE;
                RD0: begin
                    state  <= RDW;
                    rd_cnt <= CW'(RD_LAT - 2);
                end
                RDW: begin
                    if (rd_cnt == '0) begin
                        state       <= RDCAP;
                        rsp_rdata   <= reg_dout_i;
                        a_rsp_valid <= !cur_b;
                        b_rsp_valid <= cur_b;
                    end else begin
                        rd_cnt <= rd_cnt - 1'b1;
                    end
                end
                RDCAP:   state <= IDLE;
                default: state <= IDLE_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_sequencer.sv
// Directed bench for uart_reg_sequencer (AUTO_INIT=1, RD_LAT=2).
// Inputs change and outputs are sampled around the falling clock edge.
// The register-file model returns 0x53+addr one cycle after a read strobe
// and 0 otherwise, so a mistimed capture shows up as wrong rsp_rdata.
module tb_uart_reg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [15:0] cfg_div;
    logic [7:0]  cfg_lcr, cfg_fcr;
    logic        init_done;
    logic        a_valid, a_we, a_ready, a_rsp_valid;
    logic        b_valid, b_we, b_ready, b_rsp_valid;
    logic [2:0]  a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic [7:0]  rsp_rdata;
    logic        reg_wr_o, reg_rd_o;
    logic [2:0]  reg_addr_o;
    logic [7:0]  reg_din_o;
    logic [7:0]  reg_dout_i = 8'h00;

    int checks   = 0;
    int failures = 0;
    logic exp_a;

    uart_reg_sequencer #(.AUTO_INIT(1'b1), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .cfg_div(cfg_div), .cfg_lcr(cfg_lcr), .cfg_fcr(cfg_fcr),
        .init_done(init_done),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rsp_valid(a_rsp_valid),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rsp_valid(b_rsp_valid),
        .rsp_rdata(rsp_rdata),
        .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o),
        .reg_addr_o(reg_addr_o), .reg_din_o(reg_din_o),
        .reg_dout_i(reg_dout_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        reg_dout_i <= reg_rd_o ? (8'h53 + {5'd0, reg_addr_o}) : 8'h00;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Called at the falling edge of the INIT0 cycle; returns at the IDLE cycle.
    task automatic expect_init(input logic [15:0] div, input logic [7:0] lcr,
                               input logic [7:0] fcr);
        logic [2:0] ea [5];
        logic [7:0] ed [5];
        ea[0] = 3'd3; ed[0] = {1'b1, lcr[6:0]};
        ea[1] = 3'd0; ed[1] = div[7:0];
        ea[2] = 3'd1; ed[2] = div[15:8];
        ea[3] = 3'd3; ed[3] = {1'b0, lcr[6:0]};
        ea[4] = 3'd2; ed[4] = fcr;
        for (int i = 0; i < 5; i++) begin
            chkb("init_wr", reg_wr_o, 1'b1);
            chkb("init_rd", reg_rd_o, 1'b0);
            chk("init_addr", {5'd0, reg_addr_o}, {5'd0, ea[i]});
            chk("init_din", reg_din_o, ed[i]);
            chkb("init_done_low", init_done, 1'b0);
            chkb("init_b_ready", b_ready, 1'b0);
            @(negedge clk);
        end
        chkb("init_wr_end", reg_wr_o, 1'b0);
        chkb("init_done_high", init_done, 1'b1);
    endtask

    initial begin
        rst = 1'b0; cfg_start = 1'b0;
        cfg_div = 16'h0145; cfg_lcr = 8'h03; cfg_fcr = 8'hC1;
        a_valid = 1'b0; a_we = 1'b0; a_addr = 3'd0; a_wdata = 8'h00;
        // B requests a write while init is still running.
        b_valid = 1'b1; b_we = 1'b1; b_addr = 3'd5; b_wdata = 8'h3C;
        #1 rst = 1'b1;
        #2;
        chkb("rst_wr", reg_wr_o, 1'b0);
        chkb("rst_rd", reg_rd_o, 1'b0);
        chkb("rst_init_done", init_done, 1'b0);
        chkb("rst_b_ready", b_ready, 1'b0);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_addr", {5'd0, reg_addr_o}, 8'h00);

        @(negedge clk); rst = 1'b0;
        #1 chkb("idle_rst_wr", reg_wr_o, 1'b0);
        @(negedge clk);
        expect_init(16'h0145, 8'h03, 8'hC1);

        // Held B write accepted in the first IDLE cycle.
        chkb("b_ready_after_init", b_ready, 1'b1);
        chkb("a_ready_after_init", a_ready, 1'b0);
        @(negedge clk); b_valid = 1'b0; #1;
        chkb("bw_wr", reg_wr_o, 1'b1);
        chk("bw_addr", {5'd0, reg_addr_o}, 8'd5);
        chk("bw_din", reg_din_o, 8'h3C);
        chkb("bw_b_rsp", b_rsp_valid, 1'b1);
        chkb("bw_a_rsp", a_rsp_valid, 1'b0);

        // A write addr7 = 0xA5.
        @(negedge clk);
        chkb("bw_done_rsp", b_rsp_valid, 1'b0);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 3'd7; a_wdata = 8'hA5; #1;
        chkb("aw_a_ready", a_ready, 1'b1);
        chkb("aw_b_ready", b_ready, 1'b0);
        @(negedge clk); a_valid = 1'b0; #1;
        chkb("aw_wr", reg_wr_o, 1'b1);
        chkb("aw_rd", reg_rd_o, 1'b0);
        chk("aw_addr", {5'd0, reg_addr_o}, 8'd7);
        chk("aw_din", reg_din_o, 8'hA5);
        chkb("aw_a_rsp", a_rsp_valid, 1'b1);
        chkb("aw_b_rsp", b_rsp_valid, 1'b0);
        chkb("aw_a_ready_low", a_ready, 1'b0);
        @(negedge clk);
        chkb("aw_wr_one_cycle", reg_wr_o, 1'b0);
        chkb("aw_rsp_one_cycle", a_rsp_valid, 1'b0);
        chk("aw_addr_hold", {5'd0, reg_addr_o}, 8'd7);
        chk("aw_din_hold", reg_din_o, 8'hA5);

        // Both ports reading addr7: grants alternate A, B, A, B.
        a_valid = 1'b1; a_we = 1'b0; a_addr = 3'd7;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 3'd7; #1;
        for (int k = 0; k < 4; k++) begin
            exp_a = (k % 2 == 0);
            chkb("rr_a_ready", a_ready, exp_a);
            chkb("rr_b_ready", b_ready, !exp_a);
            @(negedge clk);
            chkb("rd0_rd", reg_rd_o, 1'b1);
            chkb("rd0_wr", reg_wr_o, 1'b0);
            chk("rd0_addr", {5'd0, reg_addr_o}, 8'd7);
            chkb("rd0_no_ready", a_ready | b_ready, 1'b0);
            @(negedge clk);
            chkb("rdw_rd", reg_rd_o, 1'b0);
            chk("rdw_addr", {5'd0, reg_addr_o}, 8'd7);
            chkb("rdw_no_rsp", a_rsp_valid | b_rsp_valid, 1'b0);
            @(negedge clk);
            chkb("rdcap_rd", reg_rd_o, 1'b0);
            chk("rdcap_addr", {5'd0, reg_addr_o}, 8'd7);
            chk("rdcap_data", rsp_rdata, 8'h5A);
            chkb("rdcap_a_rsp", a_rsp_valid, exp_a);
            chkb("rdcap_b_rsp", b_rsp_valid, !exp_a);
            @(negedge clk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0; #1;
        chkb("rr_idle_ready", a_ready | b_ready, 1'b0);
        chk("rdata_hold", rsp_rdata, 8'h5A);

        // cfg_start during a read: read completes, then init reruns.
        cfg_div = 16'h1234; cfg_lcr = 8'h9B; cfg_fcr = 8'h07;
        a_valid = 1'b1; a_addr = 3'd3; a_we = 1'b0; #1;
        chkb("cs_a_ready", a_ready, 1'b1);
        @(negedge clk); a_valid = 1'b0; cfg_start = 1'b1; #1;
        chkb("cs_rd0", reg_rd_o, 1'b1);
        chk("cs_addr", {5'd0, reg_addr_o}, 8'd3);
        @(negedge clk); cfg_start = 1'b0; #1;
        chkb("cs_rdw_done", init_done, 1'b1);
        @(negedge clk);
        chkb("cs_rsp", a_rsp_valid, 1'b1);
        chk("cs_rdata", rsp_rdata, 8'h56);
        chkb("cs_rdcap_done", init_done, 1'b1);
        @(negedge clk); a_valid = 1'b1; #1;
        chkb("cs_pending_no_ready", a_ready, 1'b0);
        chkb("cs_idle_done", init_done, 1'b1);
        @(negedge clk); a_valid = 1'b0;
        expect_init(16'h1234, 8'h9B, 8'h07);

        // Reset during RDW: abort without response, init reruns.
        a_valid = 1'b1; a_addr = 3'd0; a_we = 1'b0; #1;
        chkb("rr_a_ready2", a_ready, 1'b1);
        @(negedge clk); a_valid = 1'b0; #1;
        chkb("rst_rd0", reg_rd_o, 1'b1);
        @(negedge clk);
        rst = 1'b1; #1;
        chkb("rstmid_wr", reg_wr_o, 1'b0);
        chkb("rstmid_rd", reg_rd_o, 1'b0);
        chkb("rstmid_rsp", a_rsp_valid, 1'b0);
        chkb("rstmid_done", init_done, 1'b0);
        chk("rstmid_rdata", rsp_rdata, 8'h00);
        @(negedge clk); rst = 1'b0; #1;
        chkb("rstrel_rsp", a_rsp_valid, 1'b0);
        chkb("rstrel_wr", reg_wr_o, 1'b0);
        @(negedge clk);
        expect_init(16'h1234, 8'h9B, 8'h07);
        chkb("rst_final_rsp", a_rsp_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_reg_sequencer.md
Name: uart_reg_sequencer

Overview:
Bus-side controller that owns the UART register-file access port (wr/rd/addr/din/dout). After reset, or on request, it runs a fixed initialisation sequence that programs the baud divisor, line format and FIFO control. It then arbitrates single register accesses from two requesters (port A and port B), round-robin, and returns read data.

Parameters:
AUTO_INIT, 1, 1 = run the init sequence automatically after reset; 0 = wait for cfg_start.
RD_LAT, 2, cycles from the read-strobe edge to the edge at which reg_dout_i is captured (min 2).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_start  in  1  pulse: (re)run init sequence
cfg_div  in  16  baud divisor
cfg_lcr  in  8  line format; bit7 ignored
cfg_fcr  in  8  FIFO control value
init_done  out  1  init sequence complete
a_valid, b_valid  in  1  request valid
a_we, b_we  in  1  1 = write, 0 = read
a_addr, b_addr  in  3  register address
a_wdata, b_wdata  in  8  write data
a_ready, b_ready  out  1  1-cycle pulse: request accepted
a_rsp_valid, b_rsp_valid  out  1  1-cycle pulse: access complete
rsp_rdata  out  8  read data; valid with the rsp_valid pulse
reg_wr_o  out  1  register write strobe
reg_rd_o  out  1  register read strobe
reg_addr_o  out  3  register address
reg_din_o  out  8  register write data
reg_dout_i  in  8  register read data, registered in the register file

Behaviour:
- Reset: all outputs 0; init_done=0; state IDLE_RST; round-robin pointer=A.
- FSM states: IDLE_RST, INIT0..INIT4, IDLE, WR, RD0, RDW, RDCAP.
- IDLE_RST: goes to INIT0 on the next cycle if AUTO_INIT=1; otherwise waits for cfg_start.
- Init sequence: one write per cycle, each a single-cycle reg_wr_o:
  - INIT0: addr3 = {1'b1, cfg_lcr[6:0]}
  - INIT1: addr0 = cfg_div[7:0]
  - INIT2: addr1 = cfg_div[15:8]
  - INIT3: addr3 = {1'b0, cfg_lcr[6:0]}
  - INIT4: addr2 = cfg_fcr
- After INIT4: init_done=1 from the next cycle, then IDLE. cfg values are sampled in each INIT state; they must be held stable by the user.
- cfg_start in IDLE: init_done drops to 0 the next cycle and INIT0 begins. cfg_start during an access is held pending until that access completes. cfg_start during init is ignored.
- Requests are not accepted while init_done=0, and ready stays 0.
- Arbitration, in IDLE only:
  - One valid: that port is granted.
  - Both valid: the port pointed to is granted, and the pointer then flips to the other port.
  - A grant pulses x_ready in the same cycle. addr, we and wdata are latched in that cycle.
- Write: state WR drives reg_wr_o=1 for 1 cycle with the latched addr/data. x_rsp_valid pulses in the WR cycle. Returns to IDLE. Accept-to-next-accept is 2 cycles minimum.
- Read:
  - RD0 drives reg_rd_o=1 for 1 cycle.
  - RDW holds reg_addr_o stable for RD_LAT-1 cycles with reg_rd_o=0.
  - RDCAP captures reg_dout_i into rsp_rdata, and x_rsp_valid pulses that cycle.
  - reg_addr_o stays constant from RD0 through RDCAP.
- reg_rd_o and reg_wr_o are never high simultaneously and each is high for at most 1 cycle per access.
- reg_addr_o/reg_din_o hold their last value when idle.
- rsp_rdata holds its value until the next read capture.
- Requesters may write addr3 with bit7=1 (divisor access); no DLAB tracking is done.
- x_valid deasserted before acceptance: no access is issued.
- Reset mid-access: immediate abort, all strobes 0, no rsp pulse, init reruns per AUTO_INIT.

Test Plan:
- Reset, AUTO_INIT=1, cfg_div=0x0145, cfg_lcr=0x03, cfg_fcr=0xC1 -> writes (3,0x83), (0,0x45), (1,0x01), (3,0x03), (2,0xC1) on 5 consecutive cycles; init_done=1 on cycle 6.
- a_valid write addr7=0xA5 after init -> a_ready pulse, reg_wr_o for 1 cycle with addr7/0xA5, a_rsp_valid pulse, b outputs idle.
- a_valid and b_valid both held reading addr7 with reg_dout_i model=0x5A -> grants alternate A,B,A,B; each read shows reg_rd_o 1 cycle, addr stable 3 cycles, rsp_rdata=0x5A with the correct rsp_valid.
- b_valid asserted during init -> no b_ready until init_done=1, then accepted within 1 cycle.
- cfg_start pulsed mid-read -> read completes with rsp, then init_done=0 and the full 5-write sequence reruns.
- rst asserted during RDW -> strobes 0 immediately, no rsp_valid, init sequence restarts after release.
